// File: rtl/sdhci_cmd_arbiter.sv
// SD CMD-line arbiter: fixed-priority grant of NumReq command sources onto one PHY,
// response checking, watchdog timeout, and halt-with-flush after any failed command.
module sdhci_cmd_arbiter #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned ArgWidth       = 32,
  parameter int unsigned WatchdogCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*6-1:0]          req_index_i,
  input  logic [NumReq*ArgWidth-1:0]   req_arg_i,
  input  logic [NumReq*2-1:0]          req_rtype_i,
  output logic                         cmd_valid_o,
  input  logic                         cmd_ready_i,
  output logic [5:0]                   cmd_index_o,
  output logic [ArgWidth-1:0]          cmd_arg_o,
  output logic [1:0]                   cmd_rtype_o,
  input  logic                         rsp_done_i,
  input  logic [5:0]                   rsp_index_i,
  input  logic                         rsp_crc_err_i,
  input  logic                         rsp_end_err_i,
  input  logic                         rsp_timeout_i,
  output logic [NumReq-1:0]            done_o,
  output logic [3:0]                   err_o,
  output logic [NumReq-1:0]            not_issued_o,
  output logic                         halt_o,
  input  logic                         clear_halt_i,
  output logic                         busy_o
);

  localparam int unsigned WdWidth = $clog2(WatchdogCycles);
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(WatchdogCycles - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWaitRsp = 2'd2
  } state_e;

  state_e               state_r, state_d_s;
  logic [5:0]           idx_r;
  logic [ArgWidth-1:0]  arg_r;
  logic [1:0]           rtype_r;
  logic [NumReq-1:0]    owner_r;
  logic [WdWidth-1:0]   wd_r;
  logic                 cmd_valid_r;
  logic [NumReq-1:0]    done_r;
  logic [3:0]           err_r;
  logic                 halt_r;
  logic                 busy_r;

  logic [NumReq-1:0]    grant_s;
  logic [5:0]           sel_index_s;
  logic [ArgWidth-1:0]  sel_arg_s;
  logic [1:0]           sel_rtype_s;
  logic [3:0]           rsp_err_s;
  logic [3:0]           err_s;
  logic                 latch_s;
  logic                 complete_s;
  logic [NumReq-1:0]    req_ready_s;
  logic [NumReq-1:0]    not_issued_s;

  // Isolates the lowest set bit: channel 0 always has highest priority.
  function automatic logic [NumReq-1:0] lowest_one_hot(input logic [NumReq-1:0] v);
    return v & (~v + NumReq'(1));
  endfunction

  // Priority grant and one-hot mux of the winning channel's command fields.
  always_comb begin
    grant_s     = lowest_one_hot(req_valid_i);
    sel_index_s = 6'd0;
    sel_arg_s   = {ArgWidth{1'b0}};
    sel_rtype_s = 2'b00;
    for (int i = 0; i < NumReq; i++) begin
      sel_index_s = sel_index_s | ({6{grant_s[i]}} & req_index_i[i*6 +: 6]);
      sel_arg_s   = sel_arg_s | ({ArgWidth{grant_s[i]}} & req_arg_i[i*ArgWidth +: ArgWidth]);
      sel_rtype_s = sel_rtype_s | ({2{grant_s[i]}} & req_rtype_i[i*2 +: 2]);
    end
  end

  // Response checking: no-response commands ignore the PHY, R2 skips the index check.
  always_comb begin
    case (rtype_r)
      2'b00:        rsp_err_s = 4'b0000;
      2'b01:        rsp_err_s = {1'b0, rsp_end_err_i, rsp_crc_err_i, rsp_timeout_i};
      2'b10, 2'b11: rsp_err_s = {(rsp_index_i != idx_r), rsp_end_err_i, rsp_crc_err_i,
                                 rsp_timeout_i};
      default:      rsp_err_s = 4'b0000;
    endcase
  end

  // Next-state logic plus the same-cycle accept/flush pulses.
  always_comb begin
    state_d_s    = state_r;
    req_ready_s  = {NumReq{1'b0}};
    not_issued_s = {NumReq{1'b0}};
    latch_s      = 1'b0;
    complete_s   = 1'b0;
    err_s        = 4'b0000;
    case (state_r)
      StIdle: begin
        if (grant_s != {NumReq{1'b0}}) begin
          req_ready_s = grant_s;
          if (halt_r) begin
            not_issued_s = grant_s;
          end else begin
            latch_s   = 1'b1;
            state_d_s = StIssue;
          end
        end else begin
          state_d_s = StIdle;
        end
      end
      StIssue: begin
        if (cmd_ready_i) begin
          state_d_s = StWaitRsp;
        end else begin
          state_d_s = StIssue;
        end
      end
      StWaitRsp: begin
        // A real response beats a watchdog expiry landing in the same cycle.
        if (rsp_done_i) begin
          complete_s = 1'b1;
          err_s      = rsp_err_s;
          state_d_s  = StIdle;
        end else if (wd_r == WdLast) begin
          complete_s = 1'b1;
          err_s      = 4'b0001;
          state_d_s  = StIdle;
        end else begin
          state_d_s = StWaitRsp;
        end
      end
      default: state_d_s = StIdle;
    endcase
  end

  // State register, latched command, watchdog and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= StIdle;
      idx_r       <= 6'd0;
      arg_r       <= {ArgWidth{1'b0}};
      rtype_r     <= 2'b00;
      owner_r     <= {NumReq{1'b0}};
      wd_r        <= {WdWidth{1'b0}};
      cmd_valid_r <= 1'b0;
      done_r      <= {NumReq{1'b0}};
      err_r       <= 4'b0000;
      halt_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_d_s;
      busy_r  <= (state_d_s != StIdle);
      if (latch_s) begin
        idx_r       <= sel_index_s;
        arg_r       <= sel_arg_s;
        rtype_r     <= sel_rtype_s;
        owner_r     <= grant_s;
        cmd_valid_r <= 1'b1;
      end else if (state_r == StIssue && cmd_ready_i) begin
        cmd_valid_r <= 1'b0;
      end
      if (state_r == StWaitRsp) begin
        wd_r <= wd_r + WdWidth'(1);
      end else begin
        wd_r <= {WdWidth{1'b0}};
      end
      done_r <= complete_s ? owner_r : {NumReq{1'b0}};
      err_r  <= complete_s ? err_s : 4'b0000;
      // Error completion outranks a coincident clear request.
      if (complete_s && (err_s != 4'b0000)) begin
        halt_r <= 1'b1;
      end else if (clear_halt_i) begin
        halt_r <= 1'b0;
      end
    end
  end

  assign req_ready_o  = req_ready_s;
  assign not_issued_o = not_issued_s;
  assign cmd_valid_o  = cmd_valid_r;
  assign cmd_index_o  = idx_r;
  assign cmd_arg_o    = arg_r;
  assign cmd_rtype_o  = rtype_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign halt_o       = halt_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Directed bench for sdhci_cmd_arbiter: priority, ordering, error halt/flush,
// watchdog boundary, response-type masking and mid-transaction reset.
module tb_sdhci_cmd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready_o;
  logic [17:0] req_index = 18'd0;
  logic [95:0] req_arg = 96'd0;
  logic [5:0]  req_rtype = 6'd0;
  logic        cmd_valid_o;
  logic        cmd_ready = 1'b1;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [1:0]  cmd_rtype_o;
  logic        rsp_done = 1'b0;
  logic [5:0]  rsp_index = 6'd0;
  logic        rsp_crc_err = 1'b0;
  logic        rsp_end_err = 1'b0;
  logic        rsp_timeout = 1'b0;
  logic [2:0]  done_o;
  logic [3:0]  err_o;
  logic [2:0]  not_issued_o;
  logic        halt_o;
  logic        clear_halt = 1'b0;
  logic        busy_o;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [2:0]  rdy_seen;
  logic [2:0]  ni_acc;
  int          ni_cnt;
  logic        cmd_valid_seen;
  logic [5:0]  issued_q[$];
  logic [7:0]  done_q[$];

  sdhci_cmd_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_index_i  (req_index),
    .req_arg_i    (req_arg),
    .req_rtype_i  (req_rtype),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready),
    .cmd_index_o  (cmd_index_o),
    .cmd_arg_o    (cmd_arg_o),
    .cmd_rtype_o  (cmd_rtype_o),
    .rsp_done_i   (rsp_done),
    .rsp_index_i  (rsp_index),
    .rsp_crc_err_i(rsp_crc_err),
    .rsp_end_err_i(rsp_end_err),
    .rsp_timeout_i(rsp_timeout),
    .done_o       (done_o),
    .err_o        (err_o),
    .not_issued_o (not_issued_o),
    .halt_o       (halt_o),
    .clear_halt_i (clear_halt),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe mid-cycle, retire accepted requests after the edge like a real source.
  task automatic tick();
    @(negedge clk_i);
    rdy_seen = req_ready_o;
    if (not_issued_o != 3'b000) begin
      ni_acc = ni_acc | not_issued_o;
      ni_cnt++;
    end
    cmd_valid_seen = cmd_valid_seen | cmd_valid_o;
    if (cmd_valid_o && cmd_ready) issued_q.push_back(cmd_index_o);
    @(posedge clk_i);
    #1;
    req_valid = req_valid & ~rdy_seen;
    if (done_o != 3'b000) done_q.push_back({halt_o, err_o, done_o});
  endtask

  task automatic set_req(input int ch, input logic [5:0] idx, input logic [1:0] rt,
                         input logic [31:0] arg);
    req_index[ch*6 +: 6]  = idx;
    req_rtype[ch*2 +: 2]  = rt;
    req_arg[ch*32 +: 32]  = arg;
    req_valid[ch]         = 1'b1;
  endtask

  task automatic expect_issue(input string tag, input logic [5:0] idx);
    int n = 0;
    while (issued_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_issued"}, 32'(issued_q.size()), 32'd1);
    if (issued_q.size() != 0) check_eq({tag, "_idx"}, 32'(issued_q.pop_front()), 32'(idx));
  endtask

  task automatic respond(input logic [5:0] idx, input logic crc, input logic end_e,
                         input logic to, input logic clr);
    rsp_index   = idx;
    rsp_crc_err = crc;
    rsp_end_err = end_e;
    rsp_timeout = to;
    clear_halt  = clr;
    rsp_done    = 1'b1;
    tick();
    rsp_done    = 1'b0;
    rsp_crc_err = 1'b0;
    rsp_end_err = 1'b0;
    rsp_timeout = 1'b0;
    clear_halt  = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [2:0] d, input logic [3:0] e,
                             input logic h);
    logic [7:0] ent;
    check_eq({tag, "_count"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() != 0) begin
      ent = done_q.pop_front();
      check_eq({tag, "_done"}, 32'(ent[2:0]), 32'(d));
      check_eq({tag, "_err"}, 32'(ent[6:3]), 32'(e));
      check_eq({tag, "_halt"}, 32'(ent[7]), 32'(h));
    end
  endtask

  task automatic do_clear();
    clear_halt = 1'b1;
    tick();
    clear_halt = 1'b0;
  endtask

  initial begin
    ni_acc = 3'b000;
    ni_cnt = 0;
    cmd_valid_seen = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_halt", 32'(halt_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    check_eq("idle_busy", 32'(busy_o), 32'd0);

    // Simultaneous ch0/ch2: ch0 first
    set_req(0, 6'd12, 2'b10, 32'h0000_1111);
    set_req(2, 6'd0, 2'b10, 32'h0000_2222);
    expect_issue("sim_a", 6'd12);
    check_eq("sim_busy", 32'(busy_o), 32'd1);
    check_eq("sim_pending", 32'(req_valid), 32'b100);
    respond(6'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_done("sim_a", 3'b001, 4'b0000, 1'b0);
    expect_issue("sim_b", 6'd0);
    respond(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_done("sim_b", 3'b100, 4'b0000, 1'b0);

    // ch2 one cycle ahead of ch0, PHY stalls the handshake
    cmd_ready = 1'b0;
    set_req(2, 6'd8, 2'b10, 32'hCAFE_0008);
    tick();
    set_req(0, 6'd12, 2'b10, 32'h0000_000C);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_valid", 32'(cmd_valid_o), 32'd1);
      check_eq("stall_index", 32'(cmd_index_o), 32'd8);
      check_eq("stall_arg", cmd_arg_o, 32'hCAFE_0008);
    end
    check_eq("stall_rtype", 32'(cmd_rtype_o), 32'b10);
    cmd_ready = 1'b1;
    expect_issue("ord_a", 6'd8);
    respond(6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_done("ord_a", 3'b100, 4'b0000, 1'b0);
    expect_issue("ord_b", 6'd12);
    respond(6'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_done("ord_b", 3'b001, 4'b0000, 1'b0);

    // Index + CRC error halts; pending ch2 flushed, nothing reaches the PHY
    set_req(0, 6'd12, 2'b10, 32'd0);
    set_req(2, 6'd0, 2'b10, 32'd0);
    expect_issue("err", 6'd12);
    respond(6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_done("err", 3'b001, 4'b1010, 1'b1);
    ni_acc = 3'b000;
    ni_cnt = 0;
    cmd_valid_seen = 1'b0;
    repeat (100) tick();
    check_eq("flush_mask", 32'(ni_acc), 32'b100);
    check_eq("flush_pulses", 32'(ni_cnt), 32'd1);
    check_eq("flush_valid_drop", 32'(req_valid), 32'd0);
    check_eq("halt_no_cmd", 32'(cmd_valid_seen), 32'd0);
    check_eq("halt_sticky", 32'(halt_o), 32'd1);
    check_eq("halt_no_done", 32'(done_q.size()), 32'd0);

    // Watchdog: expires exactly WatchdogCycles edges after the handshake
    do_clear();
    check_eq("clear_halt", 32'(halt_o), 32'd0);
    set_req(1, 6'd18, 2'b10, 32'd0);
    expect_issue("wd", 6'd18);
    repeat (1023) tick();
    check_eq("wd_early", 32'(done_q.size()), 32'd0);
    check_eq("wd_busy", 32'(busy_o), 32'd1);
    tick();
    expect_done("wd", 3'b010, 4'b0001, 1'b1);
    do_clear();

    // R2 ignores index; no-response ignores PHY errors
    set_req(0, 6'd13, 2'b01, 32'd0);
    expect_issue("r2", 6'd13);
    respond(6'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_done("r2", 3'b001, 4'b0000, 1'b0);
    set_req(0, 6'd0, 2'b00, 32'd0);
    expect_issue("rnone", 6'd0);
    respond(6'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_done("rnone", 3'b001, 4'b0000, 1'b0);

    // Error completion coincident with clear: halt stays set
    set_req(0, 6'd5, 2'b11, 32'd0);
    expect_issue("coin", 6'd5);
    respond(6'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_done("coin", 3'b001, 4'b1000, 1'b1);
    tick();
    check_eq("coin_halt_after", 32'(halt_o), 32'd1);
    do_clear();

    // Async reset during WAIT_RSP
    set_req(1, 6'd7, 2'b10, 32'd0);
    expect_issue("rst_mid", 6'd7);
    check_eq("rst_mid_busy_pre", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(busy_o), 32'd0);
    check_eq("rst_mid_valid", 32'(cmd_valid_o), 32'd0);
    check_eq("rst_mid_done", 32'(done_o), 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    check_eq("rst_mid_no_done", 32'(done_q.size()), 32'd0);
    set_req(2, 6'd9, 2'b10, 32'd0);
    expect_issue("post_rst", 6'd9);
    respond(6'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_done("post_rst", 3'b100, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
